// File: rtl/tpu_operand_skew_feeder.sv
// tpu_operand_skew_feeder
// Buffers LANES-wide operand vectors in a small FIFO and replays them into the
// systolic array with a diagonal skew (lane k lags lane 0 by k cycles).
// Each tile is closed by LANES-1 drain cycles and a tile_done pulse that
// lines up with the last vector leaving the highest lane.
// Optional build macro: FEEDER_PARITY_EN adds per-lane even parity on FIFO
// entries and a sticky parity_err output.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no tile in progress; waits for the FIFO to hold a vector
// ST_STREAM  | pops one vector per cycle, bubbles when the FIFO runs dry
// ST_FLUSH   | tile's last vector popped; feeds bubbles until skew drains
module tpu_operand_skew_feeder #(
   parameter int DATA_WIDTH = 18,
   parameter int LANES      = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [LANES*DATA_WIDTH-1:0] in_data,
   input  logic                        in_last,
   output logic [LANES*DATA_WIDTH-1:0] out_data,
   output logic [LANES-1:0]            out_valid,
   output logic                        busy,
   output logic                        tile_done
`ifdef FEEDER_PARITY_EN
   ,
   output logic                        parity_err
`endif
);

   localparam int VEC_W   = LANES * DATA_WIDTH;
   localparam int ENTRY_W = VEC_W + 1;
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int PW      = AW + 1;
   localparam int CNT_W   = $clog2(LANES);

   localparam logic [PW-1:0]    PTR_INC    = PW'(1);
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(LANES - 1);
   localparam logic [CNT_W-1:0] CNT_DEC    = CNT_W'(1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_FLUSH  = 2'd2;

   // FIFO storage and pointers (AW index bits plus one wrap bit)
   logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic [ENTRY_W-1:0] head_entry;
   logic [VEC_W-1:0]   head_data;
   logic               head_last;

   // sequencing
   logic [1:0]         state;
   logic [CNT_W-1:0]   drain_cnt;

   // vector entering the skew network this cycle
   logic [VEC_W-1:0]   stage0_data;
   logic               stage0_valid;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // Ready is a pure function of the pointers: a pop in the same cycle does
   // not open a slot when full, which keeps in_ready off any combinational
   // path from the FSM.
   assign in_ready = !fifo_full;
   assign push     = in_valid && !fifo_full;
   assign pop      = (state == ST_STREAM) && !fifo_empty;

   assign head_entry = fifo_mem[rd_ptr[AW-1:0]];
   assign head_last  = head_entry[VEC_W];
   assign head_data  = head_entry[VEC_W-1:0];

   // FIFO write port; contents need no reset since the pointers define validity
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
      end
   end

   // FIFO pointer update
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_INC;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_INC;
         end
      end
   end

   // Tile sequencer: start on a non-empty FIFO, stream until last, then drain
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         drain_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  state <= ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (pop && head_last) begin
                  state     <= ST_FLUSH;
                  drain_cnt <= DRAIN_LOAD;
               end
            end
            ST_FLUSH: begin
               if (drain_cnt == '0) begin
                  state <= ST_IDLE;
               end else begin
                  drain_cnt <= drain_cnt - CNT_DEC;
               end
            end
            default: begin
               state     <= ST_IDLE;
               drain_cnt <= '0;
            end
         endcase
      end
   end

   // Stage-0 vector: popped entry, or an all-zero bubble
   always_comb begin
      stage0_data  = '0;
      stage0_valid = 1'b0;
      if (pop) begin
         stage0_data  = head_data;
         stage0_valid = 1'b1;
      end
   end

   // Skew network: lane k is a k+1 deep register chain carrying data and valid
   // together, so bubbles travel exactly like data.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [DATA_WIDTH-1:0] dly_data [0:k];
      logic                  dly_vld  [0:k];

      // Shift lane k's chain by one stage per cycle
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int i = 0; i <= k; i++) begin
               dly_data[i] <= '0;
               dly_vld[i]  <= 1'b0;
            end
         end else begin
            dly_data[0] <= stage0_data[k*DATA_WIDTH +: DATA_WIDTH];
            dly_vld[0]  <= stage0_valid;
            for (int i = 1; i <= k; i++) begin
               dly_data[i] <= dly_data[i-1];
               dly_vld[i]  <= dly_vld[i-1];
            end
         end
      end

      assign out_data[k*DATA_WIDTH +: DATA_WIDTH] = dly_data[k];
      assign out_valid[k]                         = dly_vld[k];
   end

   assign busy = (state != ST_IDLE);

   // The drain count was loaded with LANES-1 when the last vector left the
   // FIFO, so reaching zero coincides with that vector on the top lane.
   assign tile_done = (state == ST_FLUSH) && (drain_cnt == '0);

`ifdef FEEDER_PARITY_EN
   logic [LANES-1:0] par_mem [FIFO_DEPTH];
   logic [LANES-1:0] push_par;
   logic [LANES-1:0] head_par_calc;

   function automatic logic [LANES-1:0] lane_parity(input logic [VEC_W-1:0] vec);
      logic [LANES-1:0] p;
      p = '0;
      for (int k = 0; k < LANES; k++) begin
         p[k] = ^vec[k*DATA_WIDTH +: DATA_WIDTH];
      end
      return p;
   endfunction

   // Even parity per lane, generated on the write side and checked on the read side
   always_comb begin
      push_par      = lane_parity(in_data);
      head_par_calc = lane_parity(head_data);
   end

   // Parity sideband written alongside the FIFO entry
   always_ff @(posedge clk) begin
      if (push) begin
         par_mem[wr_ptr[AW-1:0]] <= push_par;
      end
   end

   // Sticky error flag; data is still forwarded untouched
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         parity_err <= 1'b0;
      end else if (pop && (head_par_calc != par_mem[rd_ptr[AW-1:0]])) begin
         parity_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_tpu_operand_skew_feeder.sv
// Scoreboard bench for tpu_operand_skew_feeder: accepted vectors are queued,
// each lane drains the queue in order as its out_valid fires, and timing is
// checked against a per-cycle history of valids, tile_done and busy.
module tb_tpu_operand_skew_feeder;

   localparam int DW    = 18;
   localparam int LANES = 4;
   localparam int DEPTH = 8;
   localparam int HN    = 4096;
   localparam int VW    = LANES * DW;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [VW-1:0]    in_data;
   logic             in_last;
   logic [VW-1:0]    out_data;
   logic [LANES-1:0] out_valid;
   logic             busy;
   logic             tile_done;
`ifdef FEEDER_PARITY_EN
   logic             parity_err;
`endif

   tpu_operand_skew_feeder #(
      .DATA_WIDTH(DW),
      .LANES(LANES),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_last(in_last),
      .out_data(out_data),
      .out_valid(out_valid),
      .busy(busy),
      .tile_done(tile_done)
`ifdef FEEDER_PARITY_EN
      ,
      .parity_err(parity_err)
`endif
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [VW-1:0]    exp_data [$];
   logic             exp_last [$];
   int               rd_idx [LANES];
   logic [LANES-1:0] hist_v [HN];
   logic             hist_td [HN];
   logic             hist_busy [HN];
   bit               stall_seen;

   logic [DW-1:0]    m_lane;
   logic [DW-1:0]    m_exp_lane;
   logic [VW-1:0]    m_vec;
   int               m_occ;

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Output monitor / scoreboard
   always @(negedge clk) begin
      if (cyc < HN) begin
         hist_v[cyc]    = reset ? '0 : out_valid;
         hist_td[cyc]   = reset ? 1'b0 : tile_done;
         hist_busy[cyc] = reset ? 1'b0 : busy;
      end
      if (!reset) begin
         for (int k = 0; k < LANES; k++) begin
            m_lane = out_data[k*DW +: DW];
            if (out_valid[k]) begin
               checks++;
               if (rd_idx[k] >= exp_data.size()) begin
                  errors++;
                  $display("FAIL unexpected_valid lane %0d cyc %0d: got data %h, no vector expected", k, cyc, m_lane);
               end else begin
                  m_vec      = exp_data[rd_idx[k]];
                  m_exp_lane = m_vec[k*DW +: DW];
                  if (m_lane !== m_exp_lane) begin
                     errors++;
                     $display("FAIL lane_data lane %0d cyc %0d: got %h expected %h", k, cyc, m_lane, m_exp_lane);
                  end
                  if (k == LANES-1) begin
                     checks++;
                     if (tile_done !== exp_last[rd_idx[k]]) begin
                        errors++;
                        $display("FAIL tile_done_align cyc %0d: got %b expected %b", cyc, tile_done, exp_last[rd_idx[k]]);
                     end
                  end
                  rd_idx[k]++;
               end
            end else begin
               checks++;
               if (m_lane !== '0) begin
                  errors++;
                  $display("FAIL bubble_data lane %0d cyc %0d: got %h expected 0", k, cyc, m_lane);
               end
               if (k == LANES-1) begin
                  checks++;
                  if (tile_done !== 1'b0) begin
                     errors++;
                     $display("FAIL tile_done_bubble cyc %0d: got %b expected 0", cyc, tile_done);
                  end
               end
            end
         end
         m_occ = exp_data.size() - rd_idx[0];
         checks++;
         if (in_ready !== (m_occ < DEPTH)) begin
            errors++;
            $display("FAIL in_ready cyc %0d: got %b expected %b (occupancy %0d)", cyc, in_ready, (m_occ < DEPTH), m_occ);
         end
      end
   end

   function automatic logic [VW-1:0] mk_vec(input int base, input int step);
      logic [VW-1:0] v;
      for (int k = 0; k < LANES; k++) v[k*DW +: DW] = DW'(base + k*step);
      return v;
   endfunction

   function automatic logic [VW-1:0] rnd_vec();
      logic [VW-1:0] v;
      for (int k = 0; k < LANES; k++) v[k*DW +: DW] = DW'($urandom);
      return v;
   endfunction

   function automatic logic [23:0] lane_win(input int a, input int k);
      logic [23:0] r;
      for (int i = 0; i < 24; i++) r[i] = hist_v[a+i][k];
      return r;
   endfunction

   function automatic logic [23:0] td_win(input int a);
      logic [23:0] r;
      for (int i = 0; i < 24; i++) r[i] = hist_td[a+i];
      return r;
   endfunction

   function automatic logic [23:0] busy_win(input int a);
      logic [23:0] r;
      for (int i = 0; i < 24; i++) r[i] = hist_busy[a+i];
      return r;
   endfunction

   task automatic idle_in();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   // Called at a negedge; returns at the negedge after the vector is accepted
   task automatic push_vec(input logic [VW-1:0] d, input logic last);
      logic ok;
      bit   done;
      done     = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int i = 0; i < 100 && !done; i++) begin
         ok = in_ready;
         if (!ok) stall_seen = 1;
         @(posedge clk);
         if (ok) begin
            exp_data.push_back(d);
            exp_last.push_back(last);
            done = 1;
         end
         @(negedge clk);
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL push_timeout: vector %h not accepted, in_ready=%b", d, in_ready);
      end
   endtask

   task automatic wait_drain(input int bound, input string name);
      bit ok;
      ok = 0;
      for (int i = 0; i < bound && !ok; i++) begin
         @(negedge clk);
         #1;
         if (rd_idx[LANES-1] == exp_data.size() && !busy) ok = 1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_drain: consumed %0d of %0d vectors, busy=%b", name, rd_idx[LANES-1], exp_data.size(), busy);
      end
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic chk24(input string name, input logic [23:0] got, input logic [23:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++;
      if (out_valid !== '0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
      checks++;
      if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h expected 0", out_data); end
      checks++;
      if (tile_done !== 1'b0) begin errors++; $display("FAIL rst_tile_done: got %b expected 0", tile_done); end
      reset = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== '0) begin
         errors++;
         $display("FAIL post_rst_idle: got ready=%b busy=%b valid=%b expected 1 0 0", in_ready, busy, out_valid);
      end
      @(negedge clk);
   endtask

   task automatic test_single();
      int a;
      a = cyc;
      push_vec(mk_vec(1, 1), 1'b1);
      idle_in();
      wait_drain(40, "single");
      wait_until(a + 26);
      chk24("single_lane0", lane_win(a, 0), 24'h000008);
      chk24("single_lane3", lane_win(a, 3), 24'h000040);
      chk24("single_tile_done", td_win(a), 24'h000040);
      chk24("single_busy", busy_win(a), 24'h00007C);
   endtask

   task automatic test_tile4();
      int a;
      a = cyc;
      for (int i = 0; i < 4; i++) push_vec(mk_vec(16 + i, 0), (i == 3));
      idle_in();
      wait_drain(40, "tile4");
      wait_until(a + 26);
      for (int k = 0; k < LANES; k++) begin
         chk24($sformatf("tile4_lane%0d", k), lane_win(a, k), 24'(24'hF << (3 + k)));
      end
      chk24("tile4_tile_done", td_win(a), 24'h000200);
      chk24("tile4_busy", busy_win(a), 24'h0003FC);
   endtask

   task automatic test_starve();
      int a;
      a = cyc;
      push_vec(rnd_vec(), 1'b0);
      push_vec(rnd_vec(), 1'b0);
      idle_in();
      repeat (4) @(negedge clk);
      push_vec(rnd_vec(), 1'b0);
      push_vec(rnd_vec(), 1'b1);
      idle_in();
      wait_drain(40, "starve");
      wait_until(a + 26);
      for (int k = 0; k < LANES; k++) begin
         chk24($sformatf("starve_lane%0d", k), lane_win(a, k),
               24'((24'h3 << (3 + k)) | (24'h3 << (8 + k))));
      end
      chk24("starve_tile_done", td_win(a), 24'h001000);
   endtask

   task automatic test_flush_overlap();
      int a;
      a = cyc;
      push_vec(rnd_vec(), 1'b0);
      push_vec(rnd_vec(), 1'b1);
      idle_in();
      repeat (2) @(negedge clk);
      push_vec(rnd_vec(), 1'b0);
      push_vec(rnd_vec(), 1'b1);
      idle_in();
      wait_drain(60, "overlap");
      wait_until(a + 26);
      chk24("overlap_lane0", lane_win(a, 0), 24'h000C18);
      chk24("overlap_lane3", lane_win(a, 3), 24'h0060C0);
      chk24("overlap_tile_done", td_win(a), 24'h004080);
   endtask

   task automatic test_full();
      stall_seen = 0;
      for (int i = 0; i < 14; i++) push_vec(rnd_vec(), 1'b1);
      idle_in();
      wait_drain(300, "full");
      checks++;
      if (stall_seen !== 1'b1) begin
         errors++;
         $display("FAIL full_backpressure: got stall_seen=%b expected 1", stall_seen);
      end
   endtask

   task automatic test_reset_mid();
      int a;
      int td_cnt;
      int busy_cnt;
      a = cyc;
      push_vec(rnd_vec(), 1'b1);
      for (int i = 0; i < 4; i++) push_vec(rnd_vec(), 1'b0);
      idle_in();
      wait_until(a + 9);
      #1;
      checks++;
      if (busy !== 1'b1 || out_valid[0] !== 1'b1) begin
         errors++;
         $display("FAIL pre_abort_state: got busy=%b valid0=%b expected 1 1", busy, out_valid[0]);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== '0 || out_data !== '0 || tile_done !== 1'b0) begin
         errors++;
         $display("FAIL abort_outputs: got valid=%b data=%h done=%b expected all 0", out_valid, out_data, tile_done);
      end
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_ready_busy: got ready=%b busy=%b expected 1 0", in_ready, busy);
      end
      exp_data.delete();
      exp_last.delete();
      for (int k = 0; k < LANES; k++) rd_idx[k] = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      a = cyc;
      wait_until(a + 20);
      td_cnt   = 0;
      busy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (hist_td[a+i]) td_cnt++;
         if (hist_busy[a+i]) busy_cnt++;
      end
      checks++;
      if (td_cnt != 0 || busy_cnt != 0) begin
         errors++;
         $display("FAIL abort_no_tile_done: got %0d pulses, %0d busy cycles expected 0 0", td_cnt, busy_cnt);
      end
   endtask

   initial begin
      reset = 1'b1;
      idle_in();
      for (int i = 0; i < HN; i++) begin
         hist_v[i]    = '0;
         hist_td[i]   = 1'b0;
         hist_busy[i] = 1'b0;
      end
      for (int k = 0; k < LANES; k++) rd_idx[k] = 0;
      repeat (3) @(negedge clk);
      test_reset();
      test_single();
      test_tile4();
      test_starve();
      test_flush_overlap();
      test_full();
      test_reset_mid();
      wait_drain(20, "final");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
